// File: rtl/clkgen_multi.sv
// clkgen_multi -- multi-channel programmable clock / clock-enable generator.
//
// Each channel divides in_clk by a run-time programmable integer with a
// programmable high time and start phase. It emits a registered divided
// clock (out_clk) and a one-cycle tick on every out_clk rising edge
// (out_tick). Configuration writes to a running channel are held in a
// shadow register and take effect only at the period boundary, so output
// periods are never truncated or stretched by a reconfiguration.
//
// Ports:
//   in_clk        main clock, all logic on the rising edge
//   in_rst        asynchronous active-low reset
//   in_en         per-channel run enable
//   in_sync       one-cycle pulse: restart every enabled channel at its phase
//   in_cfg_valid  configuration write request
//   in_cfg_ch     target channel
//   in_cfg_div    period in in_clk cycles (>= 2)
//   in_cfg_high   high time in in_clk cycles
//   in_cfg_phase  counter start value (< div)
//   out_cfg_ready high when no channel has a configuration pending
//   out_cfg_err   one-cycle pulse after a rejected write
//   out_clk       divided clocks, straight from flops
//   out_tick      one-cycle pulse per out_clk rising edge
module clkgen_multi #(
  parameter int MAIN_CLK_HZ = 50_000_000,
  parameter int NUM_CH      = 4,
  parameter int CTR_BITS    = 16,
  parameter int DEFAULT_DIV = MAIN_CLK_HZ / 10_000,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                in_clk,
  input  logic                in_rst,
  input  logic [NUM_CH-1:0]   in_en,
  input  logic                in_sync,
  input  logic                in_cfg_valid,
  input  logic [CH_W-1:0]     in_cfg_ch,
  input  logic [CTR_BITS-1:0] in_cfg_div,
  input  logic [CTR_BITS-1:0] in_cfg_high,
  input  logic [CTR_BITS-1:0] in_cfg_phase,
  output logic                out_cfg_ready,
  output logic                out_cfg_err,
  output logic [NUM_CH-1:0]   out_clk,
  output logic [NUM_CH-1:0]   out_tick
);

  typedef enum logic {ST_IDLE, ST_RUN} ch_state_e;
  typedef enum logic [1:0] {M_IDLE, M_START, M_RUN} ch_mode_e;

  localparam logic [CTR_BITS-1:0] DEF_DIV  = CTR_BITS'(DEFAULT_DIV);
  localparam logic [CTR_BITS-1:0] DEF_HIGH = CTR_BITS'(DEFAULT_DIV / 2);
  localparam logic [CH_W:0]       CH_LIMIT = (CH_W + 1)'(NUM_CH);

  logic [CTR_BITS-1:0] div_q   [NUM_CH], div_d   [NUM_CH];
  logic [CTR_BITS-1:0] high_q  [NUM_CH], high_d  [NUM_CH];
  logic [CTR_BITS-1:0] phase_q [NUM_CH], phase_d [NUM_CH];
  logic [CTR_BITS-1:0] sdiv_q  [NUM_CH], sdiv_d  [NUM_CH];
  logic [CTR_BITS-1:0] shigh_q [NUM_CH], shigh_d [NUM_CH];
  logic [CTR_BITS-1:0] sphase_q[NUM_CH], sphase_d[NUM_CH];
  logic [CTR_BITS-1:0] ctr_q   [NUM_CH], ctr_d   [NUM_CH];
  ch_state_e           st_q    [NUM_CH], st_d    [NUM_CH];

  logic [NUM_CH-1:0]   pend_q, pend_d, clk_d, tick_d;
  logic                err_d, cfg_bad, cfg_wr;
  ch_mode_e            mode;
  logic [CTR_BITS-1:0] ctr_nxt, hi_use;

  assign out_cfg_ready = ~|pend_q;

  always_comb begin
    cfg_bad = (in_cfg_div < CTR_BITS'(2)) || (in_cfg_phase >= in_cfg_div) ||
              ({1'b0, in_cfg_ch} >= CH_LIMIT);
    cfg_wr  = in_cfg_valid && out_cfg_ready && !cfg_bad;
    err_d   = in_cfg_valid && out_cfg_ready && cfg_bad;
    pend_d  = pend_q;
    clk_d   = '0;
    tick_d  = '0;
    mode    = M_IDLE;
    ctr_nxt = '0;
    hi_use  = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      div_d[i]    = div_q[i];
      high_d[i]   = high_q[i];
      phase_d[i]  = phase_q[i];
      sdiv_d[i]   = sdiv_q[i];
      shigh_d[i]  = shigh_q[i];
      sphase_d[i] = sphase_q[i];
      ctr_d[i]    = ctr_q[i];
      st_d[i]     = st_q[i];
      ctr_nxt     = '0;
      hi_use      = high_q[i];

      if (!in_en[i])                         mode = M_IDLE;
      else if (st_q[i] == ST_IDLE || in_sync) mode = M_START;
      else                                   mode = M_RUN;

      case (mode)
        M_START: begin
          // A pending config is committed before the restart uses it.
          st_d[i] = ST_RUN;
          if (pend_q[i]) begin
            div_d[i]   = sdiv_q[i];
            high_d[i]  = shigh_q[i];
            phase_d[i] = sphase_q[i];
            pend_d[i]  = 1'b0;
            ctr_nxt    = sphase_q[i];
            hi_use     = shigh_q[i];
          end else begin
            ctr_nxt    = phase_q[i];
          end
        end
        M_RUN: begin
          if (ctr_q[i] == div_q[i] - CTR_BITS'(1)) begin
            ctr_nxt = '0;
            if (pend_q[i]) begin
              div_d[i]   = sdiv_q[i];
              high_d[i]  = shigh_q[i];
              phase_d[i] = sphase_q[i];
              pend_d[i]  = 1'b0;
              hi_use     = shigh_q[i];
            end
          end else begin
            ctr_nxt = ctr_q[i] + CTR_BITS'(1);
          end
        end
        default: begin
          st_d[i]  = ST_IDLE;
          ctr_d[i] = phase_q[i];
        end
      endcase

      if (mode != M_IDLE) begin
        ctr_d[i]  = ctr_nxt;
        clk_d[i]  = (ctr_nxt < hi_use);
        tick_d[i] = (ctr_nxt == '0) && (hi_use != '0);
      end

      // A write landing on a wrap cycle only sets pending (pend_q was clear,
      // so the wrap above changed nothing); it commits at the next wrap.
      if (cfg_wr && ({1'b0, in_cfg_ch} == (CH_W + 1)'(i))) begin
        if (!in_en[i]) begin
          div_d[i]   = in_cfg_div;
          high_d[i]  = in_cfg_high;
          phase_d[i] = in_cfg_phase;
        end else begin
          sdiv_d[i]   = in_cfg_div;
          shigh_d[i]  = in_cfg_high;
          sphase_d[i] = in_cfg_phase;
          pend_d[i]   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        div_q[i]    <= DEF_DIV;
        high_q[i]   <= DEF_HIGH;
        phase_q[i]  <= '0;
        sdiv_q[i]   <= '0;
        shigh_q[i]  <= '0;
        sphase_q[i] <= '0;
        ctr_q[i]    <= '0;
        st_q[i]     <= ST_IDLE;
      end
      pend_q      <= '0;
      out_clk     <= '0;
      out_tick    <= '0;
      out_cfg_err <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        div_q[i]    <= div_d[i];
        high_q[i]   <= high_d[i];
        phase_q[i]  <= phase_d[i];
        sdiv_q[i]   <= sdiv_d[i];
        shigh_q[i]  <= shigh_d[i];
        sphase_q[i] <= sphase_d[i];
        ctr_q[i]    <= ctr_d[i];
        st_q[i]     <= st_d[i];
      end
      pend_q      <= pend_d;
      out_clk     <= clk_d;
      out_tick    <= tick_d;
      out_cfg_err <= err_d;
    end
  end

endmodule

// File: tb/tb_clkgen_multi.sv
// Self-checking bench for clkgen_multi (3 channels, DEFAULT_DIV = 10).
// A reference model tracks each channel as a position inside its current
// period, derived from elapsed time since the period origin; every cycle all
// outputs are compared against it. Directed sequences and a config table
// cover the multi-cycle corner cases with hand-derived constants.
module tb_clkgen_multi;

  localparam int NCH  = 3;
  localparam int CW   = 2;
  localparam int DDIV = 10;

  logic            in_clk = 1'b0;
  logic            in_rst;
  logic [NCH-1:0]  in_en;
  logic            in_sync;
  logic            in_cfg_valid;
  logic [CW-1:0]   in_cfg_ch;
  logic [15:0]     in_cfg_div, in_cfg_high, in_cfg_phase;
  logic            out_cfg_ready, out_cfg_err;
  logic [NCH-1:0]  out_clk, out_tick;

  clkgen_multi #(.NUM_CH(NCH), .CTR_BITS(16), .DEFAULT_DIV(DDIV)) dut (
    .in_clk(in_clk), .in_rst(in_rst), .in_en(in_en), .in_sync(in_sync),
    .in_cfg_valid(in_cfg_valid), .in_cfg_ch(in_cfg_ch), .in_cfg_div(in_cfg_div),
    .in_cfg_high(in_cfg_high), .in_cfg_phase(in_cfg_phase),
    .out_cfg_ready(out_cfg_ready), .out_cfg_err(out_cfg_err),
    .out_clk(out_clk), .out_tick(out_tick));

  always #5 in_clk = ~in_clk;

  int n_chk = 0;
  int n_err = 0;

  // ---------------- reference model ----------------
  int           m_div[NCH], m_high[NCH], m_phase[NCH];
  int           s_div[NCH], s_high[NCH], s_phase[NCH];
  int           m_origin[NCH], m_base[NCH];
  bit [NCH-1:0] m_pend, m_en;
  int           cyc = 0;
  logic [NCH-1:0] e_clk, e_tick;
  logic         e_err;

  function automatic int pos(int i);
    return (m_origin[i] + cyc - m_base[i]) % m_div[i];
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_div[i] = DDIV; m_high[i] = DDIV / 2; m_phase[i] = 0;
      s_div[i] = 0; s_high[i] = 0; s_phase[i] = 0;
      m_origin[i] = 0; m_base[i] = 0;
    end
    m_pend = '0; m_en = '0; e_clk = '0; e_tick = '0; e_err = 1'b0;
  endtask

  task automatic apply_shadow(int i);
    m_div[i] = s_div[i]; m_high[i] = s_high[i]; m_phase[i] = s_phase[i];
    m_pend[i] = 1'b0;
  endtask

  task automatic model_step();
    bit rdy, bad, wr;
    int cd, cp, cc, p;
    rdy = (m_pend == '0);
    cd  = int'(in_cfg_div);
    cp  = int'(in_cfg_phase);
    cc  = int'(in_cfg_ch);
    bad = (cd < 2) || (cp >= cd) || (cc >= NCH);
    wr  = in_cfg_valid && rdy && !bad;
    e_err = in_cfg_valid && rdy && bad;
    for (int i = 0; i < NCH; i++) begin
      if (!in_en[i]) begin
        m_en[i] = 1'b0;
      end else if (!m_en[i] || in_sync) begin
        if (m_pend[i]) apply_shadow(i);
        m_origin[i] = m_phase[i];
        m_base[i]   = cyc + 1;
        m_en[i]     = 1'b1;
      end else begin
        p = pos(i);
        if (p == m_div[i] - 1 && m_pend[i]) begin
          apply_shadow(i);
          m_origin[i] = 0;
          m_base[i]   = cyc + 1;
        end
      end
      if (wr && cc == i) begin
        if (!in_en[i]) begin
          m_div[i] = cd; m_high[i] = int'(in_cfg_high); m_phase[i] = cp;
        end else begin
          s_div[i] = cd; s_high[i] = int'(in_cfg_high); s_phase[i] = cp;
          m_pend[i] = 1'b1;
        end
      end
    end
    cyc++;
    for (int i = 0; i < NCH; i++) begin
      if (m_en[i]) begin
        p = pos(i);
        e_clk[i]  = (p < m_high[i]);
        e_tick[i] = (p == 0) && (m_high[i] != 0);
      end else begin
        e_clk[i] = 1'b0; e_tick[i] = 1'b0;
      end
    end
  endtask

  // One clock: model evaluates the pre-edge inputs, then all outputs compared.
  task automatic step_clk();
    @(posedge in_clk);
    if (!in_rst) model_reset(); else model_step();
    #2;
    chk("out_clk", 32'(out_clk), 32'(e_clk));
    chk("out_tick", 32'(out_tick), 32'(e_tick));
    chk("out_cfg_ready", 32'(out_cfg_ready), 32'(m_pend == '0));
    chk("out_cfg_err", 32'(out_cfg_err), 32'(e_err));
  endtask

  task automatic cfg_write(int ch, int dv, int hi, int ph);
    in_cfg_ch = CW'(ch); in_cfg_div = 16'(dv); in_cfg_high = 16'(hi);
    in_cfg_phase = 16'(ph); in_cfg_valid = 1'b1;
    step_clk();
    in_cfg_valid = 1'b0;
  endtask

  task automatic measure(int n, int ch, output int highs, output int ticks);
    highs = 0; ticks = 0;
    for (int k = 0; k < n; k++) begin
      step_clk();
      highs += int'(out_clk[ch]);
      ticks += int'(out_tick[ch]);
    end
  endtask

  typedef struct {
    int ch; int dv; int hi; int ph; bit exp_err;
  } vec_t;
  vec_t tbl[8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int hs, tk, waited, last2;
    bit got;

    tbl[0] = '{0, 10,  5, 0, 1'b0};
    tbl[1] = '{1,  1,  0, 0, 1'b1};
    tbl[2] = '{1,  8,  4, 8, 1'b1};
    tbl[3] = '{3,  8,  4, 0, 1'b1};
    tbl[4] = '{2,  0,  0, 0, 1'b1};
    tbl[5] = '{2,  2,  1, 1, 1'b0};
    tbl[6] = '{1,  9, 20, 8, 1'b0};
    tbl[7] = '{0, 10,  0, 0, 1'b0};

    in_rst = 1'b0; in_en = '0; in_sync = 1'b0; in_cfg_valid = 1'b0;
    in_cfg_ch = '0; in_cfg_div = '0; in_cfg_high = '0; in_cfg_phase = '0;
    model_reset();
    repeat (3) step_clk();
    chk("reset_clk", 32'(out_clk), 32'd0);
    chk("reset_ready", 32'(out_cfg_ready), 32'd1);

    // Default divider on ch0: period 10, high 5.
    in_rst = 1'b1; in_en = 3'b001;
    measure(100, 0, hs, tk);
    chk("default_highs", 32'(hs), 32'd50);
    chk("default_ticks", 32'(tk), 32'd10);

    // Reconfigure running ch1 from 8/4 to 4/1.
    cfg_write(1, 8, 4, 0);
    in_en = 3'b011;
    repeat (3) step_clk();
    cfg_write(1, 4, 1, 0);
    chk("ready_low_pending", 32'(out_cfg_ready), 32'd0);
    waited = 0; got = 1'b0;
    while (!got && waited < 20) begin
      step_clk(); waited++;
      got = out_cfg_ready;
    end
    chk("ready_timeout", 32'(got), 32'd1);
    measure(40, 1, hs, tk);
    chk("ch1_new_highs", 32'(hs), 32'd10);
    chk("ch1_new_ticks", 32'(tk), 32'd10);

    // Phase-locked ch0 / ch2, offsets 0 and 3, sync pulse restarts.
    in_en = 3'b000;
    step_clk();
    cfg_write(0, 12, 6, 0);
    cfg_write(2, 12, 6, 3);
    in_en = 3'b101; in_sync = 1'b1;
    step_clk();
    last2 = -1;
    for (int t = 0; t < 1200; t++) begin
      in_sync = (t == 600);
      step_clk();
      if (t == 600) last2 = -1;
      if (out_tick[2]) last2 = t;
      if (out_tick[0] && last2 >= 0) chk("ch2_lead", 32'(t - last2), 32'd3);
    end
    in_sync = 1'b0;

    // Config table on idle channels.
    in_en = 3'b000;
    step_clk();
    for (int v = 0; v < 8; v++) begin
      cfg_write(tbl[v].ch, tbl[v].dv, tbl[v].hi, tbl[v].ph);
      chk("cfg_err", 32'(out_cfg_err), 32'(tbl[v].exp_err));
      step_clk();
      chk("cfg_err_pulse", 32'(out_cfg_err), 32'd0);
    end

    // high = 0 on ch0, then high >= div.
    in_en = 3'b001;
    measure(30, 0, hs, tk);
    chk("high0_highs", 32'(hs), 32'd0);
    chk("high0_ticks", 32'(tk), 32'd0);
    in_en = 3'b000;
    step_clk();
    cfg_write(0, 10, 20, 0);
    in_en = 3'b001;
    measure(30, 0, hs, tk);
    chk("highmax_highs", 32'(hs), 32'd30);
    chk("highmax_ticks", 32'(tk), 32'd3);

    // Async reset during the (constant) high phase.
    chk("pre_reset_high", 32'(out_clk[0]), 32'd1);
    #2 in_rst = 1'b0;
    #1;
    chk("async_reset_clk", 32'(out_clk), 32'd0);
    chk("async_reset_tick", 32'(out_tick), 32'd0);
    repeat (2) step_clk();
    in_rst = 1'b1;
    measure(100, 0, hs, tk);
    chk("post_reset_highs", 32'(hs), 32'd50);
    chk("post_reset_ticks", 32'(tk), 32'd10);

    // Randomized traffic against the model.
    for (int t = 0; t < 3000; t++) begin
      for (int i = 0; i < NCH; i++)
        if ($urandom_range(15) == 0) in_en[i] = ~in_en[i];
      in_sync      = ($urandom_range(63) == 0);
      in_cfg_valid = ($urandom_range(7) == 0);
      in_cfg_ch    = CW'($urandom_range(3));
      in_cfg_div   = 16'($urandom_range(12));
      in_cfg_high  = 16'($urandom_range(14));
      in_cfg_phase = 16'($urandom_range(12));
      step_clk();
    end
    in_cfg_valid = 1'b0; in_sync = 1'b0;
    step_clk();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/clkgen_multi.md
# clkgen_multi

Multi-channel, run-time programmable clock-enable/clock generator. Each of NUM_CH channels divides the main clock by a programmable integer with programmable high time (duty) and phase offset, and emits both a registered divided clock and a single-cycle tick aligned to its rising edge. It succeeds the fixed single-output divider and sits next to the main clock input, feeding peripheral timing (serial, display, sampling) from one block. Configuration changes are glitch-free: they take effect only at a period boundary.

## Interface
- MAIN_CLK_HZ, 50_000_000, main clock frequency; documentation and default derivation only.
- NUM_CH, 4, number of independent channels (1..16).
- CTR_BITS, 16, width of divisor, high-time and phase fields and of each channel counter.
- DEFAULT_DIV, 5000, divisor loaded into every channel at reset (2 ≤ DEFAULT_DIV < 2^CTR_BITS).
- in_clk  in  1  main clock, all logic on rising edge.
- in_rst  in  1  reset, asynchronous, active-low.
- in_en  in  NUM_CH  per-channel run enable.
- in_sync  in  1  single-cycle pulse: restart all enabled channels at their phase.
- in_cfg_valid  in  1  config write request.
- in_cfg_ch  in  $clog2(NUM_CH) (min 1)  target channel.
- in_cfg_div  in  CTR_BITS  period in in_clk cycles.
- in_cfg_high  in  CTR_BITS  high time in in_clk cycles.
- in_cfg_phase  in  CTR_BITS  start count offset.
- out_cfg_ready  out  1  high when a config write can be accepted.
- out_cfg_err  out  1  one-cycle pulse: rejected write.
- out_clk  out  NUM_CH  divided clocks, driven from flip-flops.
- out_tick  out  NUM_CH  one-cycle pulse coinciding with each out_clk rising edge.

## Operation
- Per channel: active regs (div, high, phase), shadow regs + pending flag, counter ctr, registered en_q.
- Reset: active div = DEFAULT_DIV, high = DEFAULT_DIV/2, phase = 0; ctr = 0; pending = 0; en_q = 0; out_clk = 0, out_tick = 0, out_cfg_err = 0, out_cfg_ready = 1 from the first clock edge after reset release.
- Write accepted when in_cfg_valid && out_cfg_ready. out_cfg_ready = no channel pending.
- Rejection: in_cfg_div < 2, or in_cfg_phase ≥ in_cfg_div, or in_cfg_ch ≥ NUM_CH → out_cfg_err pulses next cycle, no state change.
- Accepted write to disabled channel (in_en low): active regs updated next cycle, no pending.
- Accepted write to running channel: shadow loaded, pending set; shadow copied to active on the cycle ctr wraps (ctr == div−1); new period starts with ctr = 0 under new values; pending cleared same edge.
- States per channel: IDLE (en_q = 0: ctr held at phase, out_clk = 0, out_tick = 0), START (first cycle in_en sampled high with en_q = 0, or in_sync with in_en high), RUN.
- START: ctr ← phase; out_clk ← (phase < high); out_tick ← (phase == 0 && high ≠ 0). Pending config, if any, applied first.
- RUN: ctr ← (ctr == div−1) ? 0 : ctr+1; out_clk ← (ctr_next < high); out_tick ← (ctr_next == 0 && high ≠ 0).
- high = 0 → out_clk constant 0, no ticks; high ≥ div → out_clk constant 1, ticks still once per period at ctr = 0.
- in_en falling → IDLE next edge; out_clk forced 0 (may truncate a high phase, by design).
- Simultaneous: in_sync wins over wrap; config write and wrap in the same cycle → write becomes pending, applied at next wrap; in_sync with pending → pending applied at the START.
- Counter arithmetic in CTR_BITS, no overflow (ctr < div < 2^CTR_BITS).

## Timing
- out_clk/out_tick are registered: change one in_clk edge after the counter decision cycle.
- Period exactly div cycles, high exactly min(high, div) cycles, in steady state.
- Enable-to-output latency: in_en sampled high at edge N → out_clk reflects phase at edge N+1 (en_q registered).
- Channels with equal div and started in the same cycle stay phase-locked; offset = phase difference in cycles.
- Async reset clears all flops immediately regardless of clock; reset mid-period leaves no partial pulse.

## Test plan
- Reset, in_en = 1 on ch0, DEFAULT_DIV = 10 → out_clk period 10, high 5, out_tick once per 10 cycles at rising edge.
- Running ch1 div=8 high=4; write div=4 high=1 mid-period → old 8-cycle period completes, then 4-cycle periods high 1; out_cfg_ready low until applied.
- ch0 and ch2 div=12 high=6, phase 0 and 3, in_sync pulse → ch2 rising edge 9 cycles after ch0 (ch2 starts at count 3, so it reaches 0 three cycles early relative to ch0's period end... i.e. ch2 leads ch0 by 3 cycles); offset stable over 100 periods.
- Writes with div=1, phase=div, ch=NUM_CH → out_cfg_err pulse each, configuration unchanged.
- high=0 → out_clk 0, no ticks; high=20 with div=10 → out_clk constant 1, ticks every 10.
- Assert in_rst low mid-high-phase → all out_clk 0 immediately; after release channels restart from DEFAULT_DIV.
